// File: rtl/l2_mem_sched.sv
// l2_mem_sched: arbitrates the single memory port below L2 between L2
// read-miss line fills and drains of the eviction write buffer (EWB) head.
// Reads win for latency; the EWB is drained when full, when the starvation
// counter has reached STARVE_LIMIT, or when no read is pending.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   l2_read_i, l2_addr_i      line-fill request (held until l2_resp_o)
//   l2_resp_o, l2_rdata_o     fill completion pulse and data
//   ewb_empty_i, ewb_full_i   EWB occupancy status
//   ewb_addr_i, ewb_data_i    EWB head entry
//   ewb_yumi_o                pop EWB head (1-cycle pulse)
//   mem_read_o, mem_write_o   memory request strobes (never both set)
//   mem_addr_o, mem_wdata_o   line-aligned address, write data
//   mem_rdata_i, mem_resp_i   memory read data, completion pulse
module l2_mem_sched #(
   parameter int unsigned WIDTH        = 256,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             l2_read_i,
   input  logic [31:0]      l2_addr_i,
   output logic             l2_resp_o,
   output logic [WIDTH-1:0] l2_rdata_o,
   input  logic             ewb_empty_i,
   input  logic             ewb_full_i,
   input  logic [31:0]      ewb_addr_i,
   input  logic [WIDTH-1:0] ewb_data_i,
   output logic             ewb_yumi_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic [31:0]      mem_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   input  logic [WIDTH-1:0] mem_rdata_i,
   input  logic             mem_resp_i
);

   localparam int unsigned OFF = $clog2(WIDTH / 8);
   localparam int unsigned CW  = $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
   localparam logic [31:0]   LINE_MASK  = ~((32'd1 << OFF) - 32'd1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } state_e;

   state_e         state_q, state_d;
   logic [31:0]    addr_q, addr_d;
   logic [CW-1:0]  starve_cnt_q, starve_cnt_d;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      starve_cnt_d = starve_cnt_q;
      unique case (state_q)
         IDLE: begin
            // Priority order: full EWB, starved EWB, pending read, idle drain.
            if (ewb_full_i && !ewb_empty_i) begin
               state_d = WRITE;
               addr_d  = ewb_addr_i & LINE_MASK;
            end else if ((starve_cnt_q == STARVE_MAX) && !ewb_empty_i) begin
               state_d = WRITE;
               addr_d  = ewb_addr_i & LINE_MASK;
            end else if (l2_read_i) begin
               state_d = READ;
               addr_d  = l2_addr_i & LINE_MASK;
            end else if (!ewb_empty_i) begin
               state_d = WRITE;
               addr_d  = ewb_addr_i & LINE_MASK;
            end
         end
         READ: begin
            if (mem_resp_i) begin
               state_d = IDLE;
               // Only reads that overtook a waiting EWB entry count as starvation.
               if (!ewb_empty_i && (starve_cnt_q != STARVE_MAX)) begin
                  starve_cnt_d = starve_cnt_q + CW'(1);
               end
            end
         end
         WRITE: begin
            if (mem_resp_i) begin
               state_d      = IDLE;
               starve_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Request strobes decode only the state register; completion outputs
   // pass mem_resp_i/mem_rdata_i through in the same cycle.
   always_comb begin
      mem_read_o  = (state_q == READ);
      mem_write_o = (state_q == WRITE);
      mem_addr_o  = (state_q != IDLE) ? addr_q : '0;
      mem_wdata_o = (state_q == WRITE) ? ewb_data_i : '0;
      l2_resp_o   = (state_q == READ) && mem_resp_i;
      l2_rdata_o  = l2_resp_o ? mem_rdata_i : '0;
      ewb_yumi_o  = (state_q == WRITE) && mem_resp_i;
   end

endmodule
